// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings and the arbiter state encoding.
// Commands are packed as {cs_n, ras_n, cas_n, we_n}.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_ARBIT = 3'd1;
  localparam logic [2:0] S_AREF  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  typedef enum logic [2:0] {
    ST_INIT  = S_INIT,
    ST_ARBIT = S_ARBIT,
    ST_AREF  = S_AREF,
    ST_WRITE = S_WRITE,
    ST_READ  = S_READ
  } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Engine-side buses and SDRAM pin bundle seen by the arbiter.
// The arbiter uses the slave view; the engines (or a bench) drive the master view.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
);

  logic [3:0]        i_init_cmd;
  logic [BA_W-1:0]   i_init_ba;
  logic [ADDR_W-1:0] i_init_addr;
  logic              i_init_done;

  logic              i_refresh_request;
  logic [3:0]        i_refresh_cmd;
  logic [BA_W-1:0]   i_refresh_ba;
  logic [ADDR_W-1:0] i_refresh_addr;
  logic              i_refresh_done;
  logic              o_refresh_start;

  logic              i_write_request;
  logic              i_write_done;
  logic [3:0]        i_write_cmd;
  logic [BA_W-1:0]   i_write_ba;
  logic [ADDR_W-1:0] i_write_addr;
  logic              i_write_sdram_en;
  logic [DQ_W-1:0]   i_write_data;
  logic              o_write_start;

  logic              i_read_request;
  logic              i_read_done;
  logic [3:0]        i_read_cmd;
  logic [BA_W-1:0]   i_read_ba;
  logic [ADDR_W-1:0] i_read_addr;
  logic              o_read_start;

  logic              o_sdram_cke;
  logic              o_sdram_cs_n;
  logic              o_sdram_ras_n;
  logic              o_sdram_cas_n;
  logic              o_sdram_we_n;
  logic [BA_W-1:0]   o_sdram_ba;
  logic [ADDR_W-1:0] o_sdram_addr;
  logic [DQ_W-1:0]   o_sdram_dq_out;
  logic              o_sdram_dq_oe;

  modport slave (
    input  i_init_cmd, i_init_ba, i_init_addr, i_init_done,
    input  i_refresh_request, i_refresh_cmd, i_refresh_ba, i_refresh_addr, i_refresh_done,
    output o_refresh_start,
    input  i_write_request, i_write_done, i_write_cmd, i_write_ba, i_write_addr,
    input  i_write_sdram_en, i_write_data,
    output o_write_start,
    input  i_read_request, i_read_done, i_read_cmd, i_read_ba, i_read_addr,
    output o_read_start,
    output o_sdram_cke, o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n,
    output o_sdram_ba, o_sdram_addr, o_sdram_dq_out, o_sdram_dq_oe
  );

  modport master (
    output i_init_cmd, i_init_ba, i_init_addr, i_init_done,
    output i_refresh_request, i_refresh_cmd, i_refresh_ba, i_refresh_addr, i_refresh_done,
    input  o_refresh_start,
    output i_write_request, i_write_done, i_write_cmd, i_write_ba, i_write_addr,
    output i_write_sdram_en, i_write_data,
    input  o_write_start,
    output i_read_request, i_read_done, i_read_cmd, i_read_ba, i_read_addr,
    input  o_read_start,
    input  o_sdram_cke, o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n,
    input  o_sdram_ba, o_sdram_addr, o_sdram_dq_out, o_sdram_dq_oe
  );

endinterface

// File: rtl/sdram_arbiter.sv
// Grants the SDRAM to one of refresh/write/read at a time (refresh > write > read)
// and muxes the owner's command bus onto the pins; init passes through until done.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
) (
  input logic           i_sysclk,
  input logic           i_sysrst_n,
  sdram_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  logic       refresh_start_q, refresh_start_d;
  logic       write_start_q,   write_start_d;
  logic       read_start_q,    read_start_d;

  logic [3:0]        cmd_mux;
  logic [BA_W-1:0]   ba_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [DQ_W-1:0]   dq_out;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d         = state_q;
    refresh_start_d = refresh_start_q;
    write_start_d   = write_start_q;
    read_start_d    = read_start_q;
    unique case (state_q)
      ST_INIT: begin
        if (bus.i_init_done) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (bus.i_refresh_request) begin
          state_d         = ST_AREF;
          refresh_start_d = 1'b1;
        end else if (bus.i_write_request) begin
          state_d       = ST_WRITE;
          write_start_d = 1'b1;
        end else if (bus.i_read_request) begin
          state_d      = ST_READ;
          read_start_d = 1'b1;
        end
      end
      // Only the owner's done ends a grant; a dropped request does not.
      ST_AREF: begin
        if (bus.i_refresh_done) begin
          state_d         = ST_ARBIT;
          refresh_start_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (bus.i_write_done) begin
          state_d       = ST_ARBIT;
          write_start_d = 1'b0;
        end
      end
      ST_READ: begin
        if (bus.i_read_done) begin
          state_d      = ST_ARBIT;
          read_start_d = 1'b0;
        end
      end
      default: begin
        state_d         = ST_INIT;
        refresh_start_d = 1'b0;
        write_start_d   = 1'b0;
        read_start_d    = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      state_q         <= ST_INIT;
      refresh_start_q <= 1'b0;
      write_start_q   <= 1'b0;
      read_start_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      refresh_start_q <= refresh_start_d;
      write_start_q   <= write_start_d;
      read_start_q    <= read_start_d;
    end
  end

  // Pin mux follows the registered state, so reset forces the init bus out.
  always_comb begin
    cmd_mux  = CMD_NOP;
    ba_mux   = '1;
    addr_mux = '1;
    unique case (state_q)
      ST_INIT: begin
        cmd_mux  = bus.i_init_cmd;
        ba_mux   = bus.i_init_ba;
        addr_mux = bus.i_init_addr;
      end
      ST_AREF: begin
        cmd_mux  = bus.i_refresh_cmd;
        ba_mux   = bus.i_refresh_ba;
        addr_mux = bus.i_refresh_addr;
      end
      ST_WRITE: begin
        cmd_mux  = bus.i_write_cmd;
        ba_mux   = bus.i_write_ba;
        addr_mux = bus.i_write_addr;
      end
      ST_READ: begin
        cmd_mux  = bus.i_read_cmd;
        ba_mux   = bus.i_read_ba;
        addr_mux = bus.i_read_addr;
      end
      default: begin
        cmd_mux  = CMD_NOP;
        ba_mux   = '1;
        addr_mux = '1;
      end
    endcase
  end

  assign dq_out = bus.i_write_data;

  assign bus.o_refresh_start = refresh_start_q;
  assign bus.o_write_start   = write_start_q;
  assign bus.o_read_start    = read_start_q;

  assign bus.o_sdram_cke    = 1'b1;
  assign bus.o_sdram_cs_n   = cmd_mux[3];
  assign bus.o_sdram_ras_n  = cmd_mux[2];
  assign bus.o_sdram_cas_n  = cmd_mux[1];
  assign bus.o_sdram_we_n   = cmd_mux[0];
  assign bus.o_sdram_ba     = ba_mux;
  assign bus.o_sdram_addr   = addr_mux;
  assign bus.o_sdram_dq_out = dq_out;
  assign bus.o_sdram_dq_oe  = (state_q == ST_WRITE) && bus.i_write_sdram_en;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an ownership-level model.
module tb_sdram_arbiter;

  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int DQ_W   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   cmp_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: has init finished, and who owns the SDRAM (0 none, 1 refresh, 2 write, 3 read).
  bit m_initd = 1'b0;
  int m_owner = 0;

  sdram_arbiter_if #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) bus ();

  sdram_arbiter #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) dut (
    .i_sysclk   (clk),
    .i_sysrst_n (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pins_cmd();
    return {bus.o_sdram_cs_n, bus.o_sdram_ras_n, bus.o_sdram_cas_n, bus.o_sdram_we_n};
  endfunction

  function automatic logic [2:0] starts();
    return {bus.o_refresh_start, bus.o_write_start, bus.o_read_start};
  endfunction

  // Ownership model: init gate, then fixed-priority grant, released only by the owner's done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_initd = 1'b0;
      m_owner = 0;
    end else if (!m_initd) begin
      if (bus.i_init_done) m_initd = 1'b1;
    end else if (m_owner == 0) begin
      if (bus.i_refresh_request)    m_owner = 1;
      else if (bus.i_write_request) m_owner = 2;
      else if (bus.i_read_request)  m_owner = 3;
    end else begin
      if ((m_owner == 1 && bus.i_refresh_done) ||
          (m_owner == 2 && bus.i_write_done) ||
          (m_owner == 3 && bus.i_read_done))
        m_owner = 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0]        e_cmd;
    logic [BA_W-1:0]   e_ba;
    logic [ADDR_W-1:0] e_addr;
    logic [2:0]        e_starts;
    if (cmp_en) begin
      e_starts = 3'b000;
      if (!m_initd) begin
        e_cmd = bus.i_init_cmd; e_ba = bus.i_init_ba; e_addr = bus.i_init_addr;
      end else begin
        case (m_owner)
          1: begin e_cmd = bus.i_refresh_cmd; e_ba = bus.i_refresh_ba; e_addr = bus.i_refresh_addr; e_starts = 3'b100; end
          2: begin e_cmd = bus.i_write_cmd;   e_ba = bus.i_write_ba;   e_addr = bus.i_write_addr;   e_starts = 3'b010; end
          3: begin e_cmd = bus.i_read_cmd;    e_ba = bus.i_read_ba;    e_addr = bus.i_read_addr;    e_starts = 3'b001; end
          default: begin e_cmd = 4'b0111; e_ba = '1; e_addr = '1; end
        endcase
      end
      check("model_cmd",    32'(pins_cmd()),          32'(e_cmd));
      check("model_ba",     32'(bus.o_sdram_ba),      32'(e_ba));
      check("model_addr",   32'(bus.o_sdram_addr),    32'(e_addr));
      check("model_starts", 32'(starts()),            32'(e_starts));
      check("model_dq_oe",  32'(bus.o_sdram_dq_oe),
            32'(m_initd && m_owner == 2 && bus.i_write_sdram_en));
      check("model_dq_out", 32'(bus.o_sdram_dq_out),  32'(bus.i_write_data));
      check("model_cke",    32'(bus.o_sdram_cke),     32'd1);
    end
  end

  initial begin
    bus.i_init_cmd = 4'b0010;  bus.i_init_ba = 2'b01;   bus.i_init_addr = 13'h0abc;
    bus.i_init_done = 1'b0;
    bus.i_refresh_request = 1'b0; bus.i_refresh_done = 1'b0;
    bus.i_refresh_cmd = 4'b0001; bus.i_refresh_ba = 2'b10; bus.i_refresh_addr = 13'h0400;
    bus.i_write_request = 1'b0; bus.i_write_done = 1'b0;
    bus.i_write_cmd = 4'b0100;  bus.i_write_ba = 2'b01;  bus.i_write_addr = 13'h0123;
    bus.i_write_sdram_en = 1'b0; bus.i_write_data = 16'h0000;
    bus.i_read_request = 1'b0;  bus.i_read_done = 1'b0;
    bus.i_read_cmd = 4'b0101;   bus.i_read_ba = 2'b11;   bus.i_read_addr = 13'h0456;

    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_pins_init", 32'(pins_cmd()), 32'h2);
    check("reset_starts",    32'(starts()),   32'h0);

    step(); rst_n = 1'b1;
    step(); step();
    @(negedge clk);
    check("init_hold_cmd",  32'(pins_cmd()),       32'h2);
    check("init_hold_addr", 32'(bus.o_sdram_addr), 32'h0abc);

    step(); bus.i_init_done = 1'b1;
    @(negedge clk);
    check("init_done_not_yet", 32'(pins_cmd()), 32'h2);
    step(); bus.i_init_done = 1'b0;
    @(negedge clk);
    check("arbit_cmd_nop", 32'(pins_cmd()),       32'h7);
    check("arbit_ba_ones", 32'(bus.o_sdram_ba),   32'h3);
    check("arbit_addr",    32'(bus.o_sdram_addr), 32'h1fff);
    step(); step();
    @(negedge clk);
    check("init_done_drop_ignored", 32'(pins_cmd()), 32'h7);

    step();
    bus.i_refresh_request = 1'b1; bus.i_write_request = 1'b1; bus.i_read_request = 1'b1;
    step();
    @(negedge clk);
    check("prio_refresh_only", 32'(starts()),   32'h4);
    check("aref_cmd",          32'(pins_cmd()), 32'h1);

    step(); bus.i_refresh_done = 1'b1; bus.i_refresh_request = 1'b0;
    step(); bus.i_refresh_done = 1'b0;
    @(negedge clk);
    check("refresh_released", 32'(starts()),   32'h0);
    check("gap_nop",          32'(pins_cmd()), 32'h7);
    step();
    @(negedge clk);
    check("write_granted", 32'(starts()), 32'h2);

    step(); bus.i_write_sdram_en = 1'b1; bus.i_write_data = 16'ha5a5;
    @(negedge clk);
    check("write_dq_oe",  32'(bus.o_sdram_dq_oe),  32'h1);
    check("write_dq_out", 32'(bus.o_sdram_dq_out), 32'ha5a5);
    check("write_cmd",    32'(pins_cmd()),         32'h4);
    step(); bus.i_read_done = 1'b1;
    step(); bus.i_read_done = 1'b0;
    @(negedge clk);
    check("spurious_read_done", 32'(starts()), 32'h2);
    check("model_owner_write",  32'(m_owner),  32'd2);

    step(); bus.i_write_done = 1'b1; bus.i_write_request = 1'b0; bus.i_write_sdram_en = 1'b0;
    step(); bus.i_write_done = 1'b0;
    @(negedge clk);
    check("write_released", 32'(starts()), 32'h0);
    step(); bus.i_read_request = 1'b0;
    @(negedge clk);
    check("read_granted", 32'(starts()), 32'h1);
    step(); step();
    @(negedge clk);
    check("read_hold_after_drop", 32'(starts()),   32'h1);
    check("read_cmd",             32'(pins_cmd()), 32'h5);
    step(); bus.i_read_done = 1'b1;
    step(); bus.i_read_done = 1'b0;
    @(negedge clk);
    check("read_released", 32'(starts()),   32'h0);
    check("read_rel_nop",  32'(pins_cmd()), 32'h7);

    step(); bus.i_write_request = 1'b1;
    step();
    @(negedge clk);
    check("write_regrant", 32'(starts()), 32'h2);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("async_reset_starts", 32'(starts()),       32'h0);
    check("async_reset_cmd",    32'(pins_cmd()),     32'h2);
    check("async_reset_ba",     32'(bus.o_sdram_ba), 32'h1);
    step(); rst_n = 1'b1;
    step(); step();
    @(negedge clk);
    check("post_reset_init", 32'(pins_cmd()), 32'h2);
    check("post_reset_no_start", 32'(starts()), 32'h0);

    step(); bus.i_init_done = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.i_refresh_request = ($urandom_range(0, 3) == 0);
      bus.i_write_request   = ($urandom_range(0, 1) == 0);
      bus.i_read_request    = ($urandom_range(0, 1) == 0);
      bus.i_refresh_done    = ($urandom_range(0, 3) == 0);
      bus.i_write_done      = ($urandom_range(0, 3) == 0);
      bus.i_read_done       = ($urandom_range(0, 3) == 0);
      bus.i_write_sdram_en  = ($urandom_range(0, 1) == 0);
      bus.i_write_data      = 16'($urandom);
      bus.i_init_cmd = 4'($urandom); bus.i_init_ba = 2'($urandom); bus.i_init_addr = 13'($urandom);
      bus.i_refresh_cmd = 4'($urandom); bus.i_refresh_ba = 2'($urandom); bus.i_refresh_addr = 13'($urandom);
      bus.i_write_cmd = 4'($urandom); bus.i_write_ba = 2'($urandom); bus.i_write_addr = 13'($urandom);
      bus.i_read_cmd = 4'($urandom); bus.i_read_ba = 2'($urandom); bus.i_read_addr = 13'($urandom);
      rst_n = !(i % 700 == 699);
    end
    rst_n = 1'b1;
    step(); step();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Responder end of the request/start/done handshake used by sdram_init, sdram_auto_refresh and the write/read engines.
- Receives requests from the refresh, write and read engines and grants exactly one at a time by asserting that engine's start.
- Muxes the granted engine's cmd/ba/addr (and write data) onto the SDRAM pins. Before initialisation completes, it passes sdram_init's outputs through.
- Sits between the engines and the SDRAM pads, clocked by clk_100m.

Parameters:
- ADDR_W, 13, SDRAM address width
- BA_W, 2, bank address width
- DQ_W, 16, data width

Ports:
- i_sysclk  in  1  system clock (clk_100m); single clock domain
- i_sysrst_n  in  1  asynchronous active-low reset
- i_init_cmd / i_init_ba / i_init_addr  in  4/BA_W/ADDR_W  init engine bus
- i_init_done  in  1  init complete (sticky)
- i_refresh_request  in  1  refresh engine request
- i_refresh_cmd / i_refresh_ba / i_refresh_addr  in  4/BA_W/ADDR_W  refresh bus
- i_refresh_done  in  1  refresh sequence finished
- o_refresh_start  out  1  refresh grant
- i_write_request, i_write_done  in  1  write engine handshake
- i_write_cmd / i_write_ba / i_write_addr  in  4/BA_W/ADDR_W  write bus
- i_write_sdram_en  in  1  write engine drives DQ this cycle
- i_write_data  in  DQ_W  write data
- o_write_start  out  1  write grant
- i_read_request, i_read_done  in  1  read engine handshake
- i_read_cmd / i_read_ba / i_read_addr  in  4/BA_W/ADDR_W  read bus
- o_read_start  out  1  read grant
- o_sdram_cke  out  1  constant 1
- o_sdram_cs_n / o_sdram_ras_n / o_sdram_cas_n / o_sdram_we_n  out  1 each  cmd bits 3..0
- o_sdram_ba  out  BA_W  bank
- o_sdram_addr  out  ADDR_W  address
- o_sdram_dq_out  out  DQ_W  write data
- o_sdram_dq_oe  out  1  DQ output enable

Behaviour:
- Command encoding is {cs_n, ras_n, cas_n, we_n}. NOP = 4'b0111.
- States: INIT, ARBIT, AREF, WRITE, READ. State register and the three start outputs are flops.
- Reset: state = INIT; all starts = 0. While in reset the pins follow INIT muxing, so they carry the init inputs.
- INIT: pins = init bus. When i_init_done = 1, next state = ARBIT. i_init_done deasserting later is ignored.
- ARBIT: pins = NOP, ba = all-ones, addr = all-ones. Requests are sampled with fixed priority refresh > write > read.
  - The winner's state and start flop are set on the same edge, so start is visible 1 cycle after the request is sampled.
  - No request: stay in ARBIT.
- AREF / WRITE / READ:
  - Pins = that engine's bus.
  - The matching start stays 1 until the matching done is sampled 1. On that edge: start <= 0, state <= ARBIT.
  - Done signals from non-granted engines are ignored.
  - A request dropping while granted has no effect; the grant holds until done.
- ARBIT always lasts at least 1 cycle between grants, so back-to-back grants have one NOP cycle between them.
- A request that is still high after its done is regranted (subject to priority) on the next arbitration.
- o_sdram_dq_oe = (state == WRITE) && i_write_sdram_en, combinational. o_sdram_dq_out = i_write_data, unconditionally.
- Only one start may ever be high. Starts are never high in INIT.
- Reset asserted mid-operation: immediate return to INIT with starts low; an in-flight engine is aborted by its own reset.

Decomposition:
- Shared package sdram_pkg holds:
  - command constants CMD_NOP, CMD_PRE, CMD_AREF, CMD_MRS, CMD_ACT, CMD_WR, CMD_RD;
  - the state encoding localparams.
- No sub-module. The mux is an always_comb/case on state inside this module.

Test Plan:
- Reset, then hold i_init_done = 0 with i_init_cmd = 4'b0010 → pins show 0010; all starts 0.
- i_init_done rises at cycle N → state is ARBIT at N+1; pins show 0111, ba = 2'b11, addr = 13'h1FFF.
- In ARBIT, assert refresh, write and read requests on the same cycle → only o_refresh_start = 1 on the next cycle.
  - Pulse i_refresh_done → o_refresh_start = 0, one NOP cycle, then o_write_start = 1.
- During WRITE, i_write_sdram_en = 1 with i_write_data = 16'hA5A5 → dq_oe = 1 and dq_out = A5A5.
  - Pulse i_read_done spuriously → no state change.
- During READ, drop i_read_request → o_read_start stays 1 until i_read_done; i_read_cmd = 4'b0101 appears on the pins.
- Assert i_sysrst_n = 0 mid-WRITE → starts drop asynchronously; state = INIT; pins follow the init bus.
